scan_chain_cell_sync: RTL
=========================

Name: scan_chain_cell_sync

Overview:
- Per-design scan chain element that sits directly downstream of scan_controller. One instance per tiny design; instances are daisy-chained.
- Samples the slow scan interface (clk/data/select/latch) with the fast system clock: synchroniser, edge detect, shift/load register, input latch.
- Forwards the scan interface to the next cell with fixed latency.
- Captured bits drive the design's inputs; the design's outputs are loaded back into the chain for readout.

Parameters:
- NUM_IOS, 8, width of design IO and of the shift register; PL = NUM_IOS-1.
- SYNC_STAGES, 2, synchroniser depth on all four scan inputs; minimum 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- scan_clk_in  in  1  scan clock from the upstream cell or controller.
- scan_data_in  in  1  serial data from upstream.
- scan_select_in  in  1  1 = parallel load from module_data_out; 0 = shift.
- scan_latch_en_in  in  1  rising edge copies shift_reg to module_data_in.
- scan_clk_out  out  1  forwarded scan clock.
- scan_data_out  out  1  serial data to downstream (MSB of shift_reg).
- scan_select_out  out  1  forwarded select.
- scan_latch_en_out  out  1  forwarded latch enable.
- module_data_out  in  NUM_IOS  design outputs, captured on load.
- module_data_in  out  NUM_IOS  design inputs, held between latches.
- latched  out  1  one-cycle pulse when module_data_in updates.
- shift_cnt  out  8  shifts since last latch; saturates at 255.

Behaviour:
- Reset: every register and output is 0, including synchronisers, edge history, shift_reg and module_data_in.
- Reset is asserted asynchronously; deassertion is assumed synchronous (the controller supplies a synchronised reset).
- Priming:
  - A prime counter blocks edge detection for SYNC_STAGES+1 cycles after reset.
  - An input held high at reset release is therefore not seen as a rising edge.
  - Forwarded outputs are not blocked.
- Synchronisers: each scan input passes through SYNC_STAGES flops; s_* denotes the last stage.
- Edge detect:
  - clk_rise = s_clk & ~clk_d; clk_fall = ~s_clk & clk_d; lat_rise = s_lat & ~lat_d.
  - Each uses a 1-cycle history register and is qualified by primed.
- Rising edge of scan clock:
  - If s_sel = 1: shift_reg <= module_data_out.
  - Else: shift_reg <= {shift_reg[PL-1:0], s_data}, and shift_cnt increments, saturating at 255.
  - All synchronised signals share the same depth, so sel and data are aligned with the clock edge.
- Falling edge of scan clock: scan_data_out <= shift_reg[PL].
  - Output data changes only on the falling edge, so downstream always samples the value that was stable before its rising edge (hold-safe ripple).
- Latch:
  - On lat_rise, module_data_in <= shift_reg on the next clk edge, latched = 1 for that cycle, and shift_cnt <= 0.
  - If clk_rise and lat_rise occur in the same cycle, latch takes the pre-shift shift_reg value and shift_cnt ends at 0.
- Forwarding:
  - scan_clk_out, scan_select_out and scan_latch_en_out are s_* registered once, giving latency SYNC_STAGES+1 cycles.
  - Forwarding is not gated by primed.
- Timing requirement on the upstream driver: scan clock high and low phases are each at least SYNC_STAGES+3 clk cycles. Shorter pulses are undefined; no detection is required.
- Select and latch may change only while the scan clock is low.
- Reset mid-operation clears everything immediately. module_data_in returns to 0, and the design sees 0 inputs until the next latch.
- No combinational path from any input to any output.

Decomposition:
- Shared package scan_pkg holds:
  - The default NUM_IOS.
  - The SYNC_STAGES default.
  - A localparam for the minimum phase length (SYNC_STAGES+3), for reuse by the controller's wait-state defaults.
- One natural sub-module: scan_sync_edge. It is a single-bit synchroniser plus rise/fall detector with reset and a primed input, instantiated four times (no fall output needed except for clk).
- The shift/latch datapath stays in the top module.

Test Plan:
- Shift then latch: with slow scan clock (8-cycle phases), shift 0xA5 MSB-first, then pulse latch. Expect module_data_in = 0xA5, latched high exactly one cycle, shift_cnt 8 -> 0.
- Load and readout: with module_data_out = 0x3C, pulse one clock with select = 1, then 8 clocks with select = 0. Expect scan_data_out sequence 0,0,1,1,1,1,0,0, with changes only after falling-edge detect.
- Two-cell chain: shift 16 bits 0x12,0x34 through cell0 -> cell1, then latch. Expect cell1.module_data_in = 0x12 and cell0.module_data_in = 0x34; no bit duplicated or dropped.
- Forward latency: toggle scan_clk_in. Expect scan_clk_out to follow exactly SYNC_STAGES+1 = 3 cycles later; same for select and latch.
- Reset corner: scan_clk_in held high across reset release. Expect shift_cnt = 0 and no shift. Then assert reset mid-shift. Expect module_data_in = 0, scan_data_out = 0 and shift_cnt = 0 immediately.
- Saturation and coincidence: 300 shifts give shift_cnt = 255. A latch rise coinciding with a clock rise latches the pre-shift value, and shift_cnt becomes 0.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared scan-chain constants used by the cell and by the scan controller's wait-state defaults.
package scan_pkg;
  localparam int SCAN_NUM_IOS     = 8;
  localparam int SCAN_SYNC_STAGES = 2;
  // Shortest legal scan clock high or low phase, in system clock cycles.
  localparam int SCAN_MIN_PHASE   = SCAN_SYNC_STAGES + 3;

  localparam logic [7:0] SHIFT_CNT_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == SHIFT_CNT_MAX) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/scan_chain_cell_sync_if.sv
// Serial scan link between neighbouring chain cells (or controller -> first cell).
// Protocol: data and select are set up while scan_clk is low and sampled on its rise;
// scan_latch_en rises only while scan_clk is low; each phase lasts >= SCAN_MIN_PHASE cycles.
interface scan_chain_cell_sync_if;
  logic scan_clk;
  logic scan_data;
  logic scan_select;
  logic scan_latch_en;

  modport master (output scan_clk, output scan_data, output scan_select, output scan_latch_en);
  modport slave  (input  scan_clk, input  scan_data, input  scan_select, input  scan_latch_en);
endinterface

// File: rtl/scan_sync_edge.sv
// Single-bit synchroniser with one-cycle history for rise/fall detection, gated by primed_i.
module scan_sync_edge
  import scan_pkg::*;
#(
  parameter int SYNC_STAGES = SCAN_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic primed_i,
  input  logic d_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // History keeps tracking while unprimed, so a level present at reset release never looks like an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = primed_i &  s_o & ~hist_q;
  assign fall_o = primed_i & ~s_o &  hist_q;
endmodule

// File: rtl/scan_chain_cell_sync.sv
// One scan chain cell: samples the slow scan link on clk, shifts/loads, latches design inputs, forwards the link.
module scan_chain_cell_sync
  import scan_pkg::*;
#(
  parameter int NUM_IOS     = SCAN_NUM_IOS,
  parameter int SYNC_STAGES = SCAN_SYNC_STAGES
) (
  input  logic                   clk,
  input  logic                   reset,
  scan_chain_cell_sync_if.slave  up_if,
  scan_chain_cell_sync_if.master dn_if,
  input  logic [NUM_IOS-1:0]     module_data_out,
  output logic [NUM_IOS-1:0]     module_data_in,
  output logic                   latched,
  output logic [7:0]             shift_cnt
);
  localparam int PRIME_CYCLES = SYNC_STAGES + 1;
  localparam int PW           = $clog2(PRIME_CYCLES + 1);

  logic [PW-1:0]      prime_cnt_q, prime_cnt_d;
  logic               primed;
  logic [NUM_IOS-1:0] shift_reg_q, shift_reg_d;
  logic [NUM_IOS-1:0] din_q, din_d;
  logic               data_out_q, data_out_d;
  logic               latched_q, latched_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               fwd_clk_q, fwd_sel_q, fwd_lat_q;

  logic s_clk, s_data, s_sel, s_lat;
  logic clk_rise, clk_fall, lat_rise;
  logic data_rise_unused, data_fall_unused, sel_rise_unused, sel_fall_unused, lat_fall_unused;

  assign primed = (prime_cnt_q == PW'(PRIME_CYCLES));

  scan_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .reset(reset), .primed_i(primed), .d_i(up_if.scan_clk),
    .s_o(s_clk), .rise_o(clk_rise), .fall_o(clk_fall));
  scan_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
    .clk(clk), .reset(reset), .primed_i(primed), .d_i(up_if.scan_data),
    .s_o(s_data), .rise_o(data_rise_unused), .fall_o(data_fall_unused));
  scan_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sel (
    .clk(clk), .reset(reset), .primed_i(primed), .d_i(up_if.scan_select),
    .s_o(s_sel), .rise_o(sel_rise_unused), .fall_o(sel_fall_unused));
  scan_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lat (
    .clk(clk), .reset(reset), .primed_i(primed), .d_i(up_if.scan_latch_en),
    .s_o(s_lat), .rise_o(lat_rise), .fall_o(lat_fall_unused));

  always_comb begin
    prime_cnt_d = primed ? prime_cnt_q : prime_cnt_q + PW'(1);
    shift_reg_d = shift_reg_q;
    data_out_d  = data_out_q;
    din_d       = din_q;
    cnt_d       = cnt_q;
    latched_d   = lat_rise;
    if (clk_rise) begin
      shift_reg_d = s_sel ? module_data_out : {shift_reg_q[NUM_IOS-2:0], s_data};
    end
    if (clk_fall) begin
      data_out_d = shift_reg_q[NUM_IOS-1];
    end
    // A latch coinciding with a shift captures the pre-shift register and wins the counter.
    if (lat_rise) begin
      din_d = shift_reg_q;
      cnt_d = '0;
    end else if (clk_rise && !s_sel) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prime_cnt_q <= '0;
      shift_reg_q <= '0;
      data_out_q  <= 1'b0;
      din_q       <= '0;
      cnt_q       <= '0;
      latched_q   <= 1'b0;
      fwd_clk_q   <= 1'b0;
      fwd_sel_q   <= 1'b0;
      fwd_lat_q   <= 1'b0;
    end else begin
      prime_cnt_q <= prime_cnt_d;
      shift_reg_q <= shift_reg_d;
      data_out_q  <= data_out_d;
      din_q       <= din_d;
      cnt_q       <= cnt_d;
      latched_q   <= latched_d;
      fwd_clk_q   <= s_clk;
      fwd_sel_q   <= s_sel;
      fwd_lat_q   <= s_lat;
    end
  end

  assign dn_if.scan_clk      = fwd_clk_q;
  assign dn_if.scan_data     = data_out_q;
  assign dn_if.scan_select   = fwd_sel_q;
  assign dn_if.scan_latch_en = fwd_lat_q;
  assign module_data_in      = din_q;
  assign latched             = latched_q;
  assign shift_cnt           = cnt_q;
endmodule
